// File: rtl/pool_sched_pkg.sv
// Shared types and sizing helpers for the pooling sequencer.
package pool_sched_pkg;

    typedef enum logic [2:0] {IDLE, CH_RST, FEED, DRAIN, NEXT, FIN} state_t;

    localparam int M_DEF = 4;
    localparam int P_DEF = 2;

    function automatic int pix_per_ch(input int m);
        return m * m;
    endfunction

    function automatic int out_per_ch(input int m, input int p);
        return (m / p) * (m / p);
    endfunction

    localparam int PIX_PER_CH = pix_per_ch(M_DEF);
    localparam int OUT_PER_CH = out_per_ch(M_DEF, P_DEF);

endpackage

// File: rtl/pool_addr_gen.sv
// Channel/pixel/output counters and base accumulators; forms RAM addresses.
module pool_addr_gen
    import pool_sched_pkg::*;
#(
    parameter int M      = M_DEF,
    parameter int P      = P_DEF,
    parameter int ADDR_W = 12,
    parameter int CH_W   = 5
) (
    input  logic              clk,
    input  logic              master_rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [CH_W-1:0]   num_ch,
    input  logic              ch_clr,
    input  logic              pix_inc,
    input  logic              out_inc,
    input  logic              ch_next,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              pix_last,
    output logic              out_full,
    output logic              ch_last
);
    localparam int PIX_N = pix_per_ch(M);
    localparam int OUT_N = out_per_ch(M, P);
    localparam int PIX_W = $clog2(PIX_N + 1);
    localparam int OUT_W = $clog2(OUT_N + 1);

    logic [CH_W-1:0]   ch, num_ch_q;
    logic [ADDR_W-1:0] ch_in_base, ch_out_base;
    logic [PIX_W-1:0]  pix_cnt;
    logic [OUT_W-1:0]  out_cnt;

    assign rd_addr  = ch_in_base + ADDR_W'(pix_cnt);
    assign wr_addr  = ch_out_base + ADDR_W'(out_cnt);
    assign pix_last = pix_cnt == PIX_W'(PIX_N - 1);
    assign out_full = out_cnt == OUT_W'(OUT_N);
    assign ch_last  = ({1'b0, ch} + 1'b1) == {1'b0, num_ch_q};

    // Bases advance by constant strides, so no multiplier is needed per channel.
    always_ff @(posedge clk) begin
        if (master_rst) begin
            ch          <= '0;
            num_ch_q    <= '0;
            ch_in_base  <= '0;
            ch_out_base <= '0;
            pix_cnt     <= '0;
            out_cnt     <= '0;
        end else begin
            if (load) begin
                ch          <= '0;
                num_ch_q    <= num_ch;
                ch_in_base  <= in_base;
                ch_out_base <= out_base;
            end else if (ch_next) begin
                ch          <= ch + 1'b1;
                ch_in_base  <= ch_in_base + ADDR_W'(PIX_N);
                ch_out_base <= ch_out_base + ADDR_W'(OUT_N);
            end
            if (ch_clr) begin
                pix_cnt <= '0;
                out_cnt <= '0;
            end else begin
                if (pix_inc) pix_cnt <= pix_cnt + 1'b1;
                if (out_inc) out_cnt <= out_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_sched.sv
// Per-channel sequencer: reset pooler, stream M*M pixels, drain, write results.
module pool_sched
    import pool_sched_pkg::*;
#(
    parameter int M         = M_DEF,
    parameter int P         = P_DEF,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int CH_W      = 5,
    parameter int DRAIN_MAX = 64
) (
    input  logic              clk,
    input  logic              master_rst,
    input  logic              start,
    input  logic [CH_W-1:0]   num_ch,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pool_rst,
    output logic              pool_ce,
    output logic [DATA_W-1:0] pool_data_in,
    input  logic [DATA_W-1:0] pool_data_out,
    input  logic              pool_valid,
    input  logic              pool_end,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    localparam int DR_W = $clog2(DRAIN_MAX + 1);

    state_t            state;
    logic              rd_en_d;
    logic [DR_W-1:0]   drain_cnt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic              pix_last, out_full, ch_last, wr_ok;
    logic              unused_pool_end;

    assign unused_pool_end = pool_end;

    assign rd_en        = state == FEED;
    assign pool_rst     = master_rst | (state == CH_RST);
    assign pool_ce      = rd_en_d | (state == DRAIN);
    assign pool_data_in = rd_en_d ? rd_data : '0;
    // Results past the per-channel quota are surplus and never written.
    assign wr_ok        = pool_valid && (state == FEED || state == DRAIN) && !out_full;

    pool_addr_gen #(.M(M), .P(P), .ADDR_W(ADDR_W), .CH_W(CH_W)) u_addr (
        .clk       (clk),
        .master_rst(master_rst),
        .load      (state == IDLE && start),
        .in_base   (in_base),
        .out_base  (out_base),
        .num_ch    (num_ch),
        .ch_clr    (state == CH_RST),
        .pix_inc   (state == FEED),
        .out_inc   (wr_ok),
        .ch_next   (state == NEXT),
        .rd_addr   (rd_addr),
        .wr_addr   (wr_addr_nxt),
        .pix_last  (pix_last),
        .out_full  (out_full),
        .ch_last   (ch_last)
    );

    always_ff @(posedge clk) begin
        if (master_rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_en_d   <= 1'b0;
            drain_cnt <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            rd_en_d <= rd_en;
            wr_en   <= wr_ok;
            if (wr_ok) begin
                wr_addr <= wr_addr_nxt;
                wr_data <= pool_data_out;
            end
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy  <= 1'b1;
                    err   <= 1'b0;
                    state <= (num_ch == '0) ? FIN : CH_RST;
                end
                CH_RST: begin
                    drain_cnt <= '0;
                    state     <= FEED;
                end
                FEED: if (pix_last) state <= DRAIN;
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (out_full) begin
                        state <= NEXT;
                    end else if (drain_cnt == DR_W'(DRAIN_MAX - 1)) begin
                        // Pooler stalled: flag and abandon the remaining channels.
                        err   <= 1'b1;
                        state <= FIN;
                    end
                end
                NEXT: state <= ch_last ? FIN : CH_RST;
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
